fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; every register updates on its rising edge.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL: stall  in  1  hazard stall from the hazard unit; holds the PC and fetch outputs.
REQ-004 SHALL: flush  in  1  exception/eret redirect request.
REQ-005 SHALL: flush_pc  in  32  redirect target (0xbfc00380 or EPC).
REQ-006 SHALL: branchD / jumpD / jrD  in  1 each  taken-branch, j/jal, jr/jalr indications from decode.
REQ-007 SHALL: pcD  in  32  PC of the instruction currently in decode.
REQ-008 SHALL: extend_immD  in  32  sign-extended branch offset.
REQ-009 SHALL: instr_indexD  in  26  J-type target field.
REQ-010 SHALL: jr_srcD  in  32  forwarded jr target.
REQ-011 SHALL: next_is_in_slotD  in  1  decode holds a branch or jump.
REQ-012 SHALL: inst_sram_en  out  1  SRAM read enable.
REQ-013 SHALL: inst_sram_wen  out  4  SRAM write enables, tied 0.
REQ-014 SHALL: inst_sram_addr  out  32  SRAM read address.
REQ-015 SHALL: inst_sram_wdata  out  32  SRAM write data, tied 0.
REQ-016 SHALL: inst_sram_rdata  in  32  SRAM read data, valid one cycle after the address.
REQ-017 SHALL: pcF  out  32  PC being fetched, to decode.
REQ-018 SHALL: instrF  out  32  instruction word for the decode stage.
REQ-019 SHALL: inst_sram_enF  out  1  fetch-valid qualifier for decode.
REQ-020 SHALL: adelF  out  1  instruction address error.
REQ-021 SHALL: in_delayslotF  out  1  fetched instruction is in a delay slot.

Function
REQ-022 SHALL: pc_reg is the PC register; inst_sram_addr = pcF = pc_reg.
REQ-023 SHALL: next-PC priority: flush -> flush_pc; else stall -> hold; else jrD -> jr_srcD; else branchD -> pcD+4+(extend_immD<<2); else jumpD -> {pcD+4 [31:28], instr_indexD, 2'b00}; else pc_reg+4.
REQ-024 SHALL: all additions are 32-bit modulo; 0xfffffffc+4 wraps to 0x00000000.
REQ-025 SHALL: adelF = (pc_reg[1:0] != 0), combinational.
REQ-026 SHALL: inst_sram_en = ~rst & ~adelF; inst_sram_enF = inst_sram_en.
REQ-027 SHALL: in_delayslotF = next_is_in_slotD & ~flush.
REQ-028 SHALL: the hold buffer is hold_buf[31:0] plus a hold_valid flag.
REQ-029 SHALL: at a rising edge with stall=1 and hold_valid=0, capture inst_sram_rdata into hold_buf and set hold_valid=1.
REQ-030 SHALL: stall=0 or flush=1 clears hold_valid at the edge; hold_buf is not updated while hold_valid=1.
REQ-031 SHALL: instrF = hold_valid ? hold_buf : inst_sram_rdata.
REQ-032 SHALL: simultaneous flush and stall: flush wins; pc_reg<=flush_pc and hold_valid<=0.
REQ-033 SHALL: simultaneous jrD and branchD: jrD wins (REQ-023 order).
REQ-034 SHALL: redirect latency: a target selected in cycle N appears on inst_sram_addr in cycle N+1, and its data on instrF in cycle N+2.

Reset
REQ-035 SHALL: while rst=1: pc_reg<=0xbfc00000, hold_valid<=0, hold_buf<=0; inst_sram_en=0 combinationally.
REQ-036 SHALL: the first cycle after rst deasserts presents addr 0xbfc00000 with inst_sram_en=1.
REQ-037 SHALL: rst asserted mid-stall or mid-redirect overrides all other inputs.

Verification
REQ-038 SHALL: reset sequence: release rst, no stall -> inst_sram_addr = 0xbfc00000, 0xbfc00004, 0xbfc00008 on successive cycles, inst_sram_en=1.
REQ-039 SHALL: taken branch: branchD=1, pcD=0xbfc00010, extend_immD=0xfffffffe -> next addr 0xbfc0000c; jumpD with instr_indexD=0x0000100 and pcD=0xbfc00010 -> 0xb0000400.
REQ-040 SHALL: stall for 3 cycles when rdata=0x24020001 -> instrF stays 0x24020001 for all stall cycles; addr unchanged; after release, addr advances by 4.
REQ-041 SHALL: flush with stall=1, flush_pc=0xbfc00380 -> next addr 0xbfc00380, hold_valid=0, in_delayslotF=0.
REQ-042 SHALL: jr to 0x80000002 -> adelF=1, inst_sram_en=0, inst_sram_enF=0 in the following cycle.
REQ-043 SHALL: rst asserted during a 2-cycle stall -> next cycle addr=0xbfc00000, hold_valid=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect priority, SRAM address generation,
// and a hold buffer that keeps the fetched word stable across hazard stalls.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branchD,
    input  logic        jumpD,
    input  logic        jrD,
    input  logic [31:0] pcD,
    input  logic [31:0] extend_immD,
    input  logic [25:0] instr_indexD,
    input  logic [31:0] jr_srcD,
    input  logic        next_is_in_slotD,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        inst_sram_enF,
    output logic        adelF,
    output logic        in_delayslotF
);

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        hold_valid_q, hold_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] pcd_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        pcd_plus4     = pcD + 32'd4;
        branch_target = pcd_plus4 + {extend_immD[29:0], 2'b00};
        jump_target   = {pcd_plus4[31:28], instr_indexD, 2'b00};
    end

    // Redirect priority: flush > stall > jr > branch > jump > sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (flush)        pc_d = flush_pc;
        else if (stall)   pc_d = pc_q;
        else if (jrD)     pc_d = jr_srcD;
        else if (branchD) pc_d = branch_target;
        else if (jumpD)   pc_d = jump_target;
    end

    // The first stalled edge captures the word; later stalled edges keep it.
    always_comb begin
        hold_valid_d = 1'b0;
        hold_buf_d   = hold_buf_q;
        if (!flush && stall) begin
            hold_valid_d = 1'b1;
            if (!hold_valid_q) hold_buf_d = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            hold_buf_q   <= 32'h0;
            hold_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_comb begin
        adelF           = (pc_q[1:0] != 2'b00);
        inst_sram_en    = ~rst & ~adelF;
        inst_sram_enF   = inst_sram_en;
        inst_sram_wen   = 4'h0;
        inst_sram_wdata = 32'h0;
        inst_sram_addr  = pc_q;
        pcF             = pc_q;
        instrF          = hold_valid_q ? hold_buf_q : inst_sram_rdata;
        in_delayslotF   = next_is_in_slotD & ~flush;
    end

endmodule
